// File: rtl/rom_streamer.sv
// Reads a programmed window of a synchronous-read ROM and presents it as a
// valid/ready byte stream, using a 2-entry buffer to cover the ROM read latency.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; base/length latched when start is accepted
// S_RUN   | issuing ROM reads and draining beats to the stream port
// S_DONE  | single-cycle done pulse, then back to idle
module rom_streamer #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 16,
   parameter int LEN_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [LEN_BITS-1:0]  length,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] rom_addr,
   input  logic [DATA_BITS-1:0] rom_data,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [ADDR_BITS-1:0] issue_ptr;
   logic [LEN_BITS-1:0]  issue_left;
   logic [LEN_BITS-1:0]  beat_left;
   logic                 pend;
   logic [DATA_BITS-1:0] fifo_mem [2];
   logic                 wr_idx;
   logic                 rd_idx;
   logic [1:0]           fifo_count;
   logic                 push;
   logic                 pop;
   logic                 start_acc;
   logic                 issue_en;
   logic [2:0]           occupancy;

   assign start_acc = (state == S_IDLE) && start;
   assign push      = pend;
   assign pop       = m_valid && m_ready;

   // Buffered plus in-flight words after this edge; never let it exceed two.
   assign occupancy = {1'b0, fifo_count} + {2'b00, pend} - {2'b00, pop};
   assign issue_en  = (state == S_RUN) && (issue_left != '0) && (occupancy < 3'd2);

   assign rom_addr = issue_ptr;
   assign m_valid  = (fifo_count != 2'd0);
   assign m_data   = fifo_mem[rd_idx];
   assign m_last   = m_valid && (beat_left == LEN_BITS'(1));
   assign busy     = (state == S_RUN);
   assign done     = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (pop && (beat_left == LEN_BITS'(1))) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_ptr  <= '0;
         issue_left <= '0;
         beat_left  <= '0;
         pend       <= 1'b0;
      end else begin
         pend <= issue_en;
         if (start_acc) begin
            issue_ptr  <= base_addr;
            issue_left <= length;
            beat_left  <= length;
         end else begin
            if (issue_en) begin
               issue_ptr  <= issue_ptr + ADDR_BITS'(1);
               issue_left <= issue_left - LEN_BITS'(1);
            end
            if (pop && (beat_left != '0)) begin
               beat_left <= beat_left - LEN_BITS'(1);
            end
         end
      end
   end

   // ROM data is captured one cycle after its address was issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_idx      <= 1'b0;
         rd_idx      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_idx] <= rom_data;
            wr_idx           <= ~wr_idx;
         end
         if (pop) begin
            rd_idx <= ~rd_idx;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer: table of transfers checked against a byte scoreboard,
// plus hand-written reset-mid-transfer sequence.
module tb_rom_streamer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] length;
   logic        busy;
   logic        done;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   logic [7:0]  rom_mem [0:65535];

   typedef struct {
      logic [15:0] base;
      logic [15:0] len;
      int          mode;       // 0 ready always, 1 fixed toggle pattern, 2 random
      bit          restart;    // pulse start again while busy
      int          exp_first;  // cycle of first m_valid, 0 = never
      int          exp_done;   // cycle of done, 0 = one after last handshake
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t sb_q[$];
   int   checks;
   int   errors;

   rom_streamer #(.DATA_BITS(8), .ADDR_BITS(16), .LEN_BITS(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic ready_for(input int mode, input int c);
      logic [7:0] pat;
      pat = 8'b01101001;
      if (mode == 0) return 1'b1;
      if (mode == 1) return pat[c % 8];
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_xfer(input vec_t v);
      int          cyc;
      int          first_v;
      int          last_hs;
      int          done_cyc;
      int          beats;
      bit          busy_ok;
      bit          ahead_ok;
      bit          stall_prev;
      logic [7:0]  held_d;
      logic        held_l;
      logic [15:0] a;
      exp_t        e;

      for (int i = 0; i < int'(v.len); i++) begin
         a      = v.base + 16'(i);
         e.data = rom_mem[a];
         e.last = (i == int'(v.len) - 1);
         sb_q.push_back(e);
      end

      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = v.base;
      length    = v.len;
      m_ready   = ready_for(v.mode, 0);
      first_v = 0; last_hs = 0; done_cyc = 0; beats = 0;
      busy_ok = 1'b1; ahead_ok = 1'b1; stall_prev = 1'b0;
      held_d = '0; held_l = 1'b0;
      cyc = 0;

      while (done_cyc == 0 && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         start = v.restart && (cyc == 2);
         if (start) begin
            base_addr = 16'h0077;
            length    = 16'd9;
         end
         if (cyc == 1) check("rom_addr_base", 32'(rom_addr), 32'(v.base));
         if (done) begin
            done_cyc = cyc;
            if (busy !== 1'b0) busy_ok = 1'b0;
         end else if (busy !== (v.len != 16'd0)) begin
            busy_ok = 1'b0;
         end
         if (v.len != 16'd0 && !done &&
             (int'(16'(rom_addr - v.base)) - beats > 2 || int'(16'(rom_addr - v.base)) < beats))
            ahead_ok = 1'b0;
         if (stall_prev) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(held_d));
            check("stall_last", 32'(m_last), 32'(held_l));
         end
         if (m_valid && first_v == 0) first_v = cyc;
         m_ready = ready_for(v.mode, cyc);
         if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_extra_beat", 32'(m_data), 32'hffff_ffff);
            end else begin
               e = sb_q.pop_front();
               check("beat_data", 32'(m_data), 32'(e.data));
               check("beat_last", 32'(m_last), 32'(e.last));
            end
            last_hs = cyc;
            beats++;
         end
         stall_prev = m_valid && !m_ready;
         held_d     = m_data;
         held_l     = m_last;
      end

      check("done_seen", 32'(done_cyc != 0), 32'd1);
      check("beat_count", 32'(beats), 32'(v.len));
      check("first_valid_cycle", 32'(first_v), 32'(v.exp_first));
      if (v.exp_done != 0) check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
      else                 check("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
      check("busy_profile", 32'(busy_ok), 32'd1);
      check("addr_ahead_le2", 32'(ahead_ok), 32'd1);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      sb_q.delete();

      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
   endtask

   vec_t vecs [7];
   vec_t vpost;
   bit   quiet_ok;

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 65536; i++) rom_mem[i] = 8'(i);
      rom_mem[16'hFFFE] = 8'hAA;
      rom_mem[16'hFFFF] = 8'hBB;
      rom_mem[16'h0000] = 8'hCC;
      rom_mem[16'h0001] = 8'hDD;

      vecs[0] = '{16'h0010, 16'd4,  0, 1'b0, 3, 7};
      vecs[1] = '{16'h0010, 16'd4,  1, 1'b0, 3, 0};
      vecs[2] = '{16'h0020, 16'd0,  0, 1'b0, 0, 1};
      vecs[3] = '{16'h0005, 16'd1,  0, 1'b0, 3, 4};
      vecs[4] = '{16'h0040, 16'd6,  0, 1'b1, 3, 9};
      vecs[5] = '{16'h0100, 16'd10, 2, 1'b0, 3, 0};
      vecs[6] = '{16'hFFFE, 16'd4,  0, 1'b0, 3, 7};

      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 7; k++) run_xfer(vecs[k]);

      // Reset after two of eight beats.
      @(posedge clk); #1;
      start = 1'b1; base_addr = 16'h0030; length = 16'd8; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_beat0_valid", 32'(m_valid), 32'd1);
      check("mid_beat0_data", 32'(m_data), 32'h30);
      @(posedge clk); #1;
      check("mid_beat1_data", 32'(m_data), 32'h31);
      @(posedge clk); #1;
      check("mid_busy_before_rst", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_last", 32'(m_last), 32'd0);
      check("mid_rst_addr", 32'(rom_addr), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      quiet_ok = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (m_valid || busy || done) quiet_ok = 1'b0;
      end
      check("post_rst_quiet", 32'(quiet_ok), 32'd1);

      vpost = '{16'h0050, 16'd3, 0, 1'b0, 3, 6};
      run_xfer(vpost);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_streamer.md
Name: rom_streamer

Overview:
Reader/sequencer for the synchronous-read ROM. It walks a programmed address window and turns the 1-cycle-latency ROM read port into a valid/ready byte stream. Downstream users include the UPDI transmit path, which programs a firmware image into the target. A 2-entry output buffer absorbs read latency under backpressure and sustains one beat per cycle when m_ready is held high.

Parameters:
DATA_BITS, 8, width of ROM word and stream data
ADDR_BITS, 16, ROM address width; must match the ROM instance
LEN_BITS, 16, width of transfer length field

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; launches a transfer when idle
base_addr  input  ADDR_BITS  first ROM address, sampled on accepted start
length  input  LEN_BITS  number of words to stream, sampled on accepted start
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse at end of transfer
rom_addr  output  ADDR_BITS  to ROM addr port (combinational from issue counter)
rom_data  input  DATA_BITS  from ROM out port; valid the cycle after the address is sampled
m_data  output  DATA_BITS  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready
m_last  output  1  high with the final beat of a transfer

Behaviour:
- Clock is clk; reset is asynchronous and active-low. Asserting rst_n=0 immediately clears all state: FSM=IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, rom_addr=0, FIFO empty, pending flag=0, counters=0.
- FSM states:
  - IDLE: start=1 is accepted; latch base_addr into issue pointer and length into issue_left and beat_left.
    - length!=0 -> RUN.
    - length==0 -> DONE_ST; no beats are produced.
  - RUN: issue reads while issue_left>0. When beat_left reaches 0 on the last handshake -> DONE_ST.
  - DONE_ST: done=1 for exactly this cycle; busy=0 here; -> IDLE.
- start is ignored outside IDLE, including while busy.
- Issue rule: issue_en = RUN && issue_left>0 && (fifo_count + pend - pop) < 2, where pop = m_valid && m_ready.
  - rom_addr = issue pointer.
  - On an issue edge: pointer += 1 (mod 2^ADDR_BITS; wraps 0xFFFF->0x0000), issue_left -= 1, pend <= 1. Otherwise pend <= 0.
- Capture: when pend=1, rom_data is written into the FIFO at the next edge.
- FIFO: 2 entries. Simultaneous push and pop is legal; overflow is impossible by the issue rule. m_valid = fifo non-empty; m_data = FIFO head.
- Handshake: a beat transfers on an edge with m_valid && m_ready. m_data, m_valid and m_last stay stable while m_valid && !m_ready.
- m_last = m_valid && beat_left==1. beat_left decrements on each pop.
- Latency: start high in cycle 0 -> rom_addr=base in cycle 1 -> rom_data valid in cycle 2 -> m_valid=1 in cycle 3.
- Throughput: with m_ready held high, one beat per cycle, no bubbles.
- done pulses in the cycle after the m_last handshake; busy falls in that same cycle.
- A new start is accepted in the cycle after done (IDLE).
- Reset mid-transfer discards buffered and in-flight data with no further beats.

Test Plan:
- ROM preloaded data[i]=i. Start, base=0x0010, length=4, m_ready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles; first m_valid in cycle 3; m_last on 0x13; done one cycle later.
- Same transfer, m_ready toggled 1,0,0,1,0,1... -> the same four bytes in order with no loss or duplication; data held stable while stalled; rom_addr never runs more than 2 ahead of the last pop.
- length=0 -> no m_valid ever; done pulses in cycle 1; busy never high.
- length=1, base=0x0005 -> a single beat 0x05 with m_last=1, then done.
- Wrap: base=0xFFFE, length=4, ROM[0xFFFE]=0xAA, [0xFFFF]=0xBB, [0]=0xCC, [1]=0xDD -> beats AA BB CC DD.
- Start pulsed again while busy -> ignored, stream unchanged.
- rst_n low after 2 of 8 beats -> m_valid and busy drop immediately.
- After reset, a new start -> a clean stream from the new base.
